// File: rtl/stream_out_collector.sv
// Egress framing stage: buffers datapath phits in a first-word-fall-through FIFO and
// emits them as one message of a programmed length, tagging the final phit with out_last.
module stream_out_collector #(
    parameter int PHIT_SIZE = 512,
    parameter int DEPTH     = 16,
    parameter int LEN_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     msg_len,
    input  logic                 in_valid,
    input  logic [PHIT_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PHIT_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [LEN_W-1:0]     phit_cnt
);

    // state     | meaning
    // S_IDLE    | waiting for start; FIFO drained
    // S_COLLECT | accepting phits until len have been taken
    // S_DRAIN   | input closed; waiting for the last-tagged phit to leave
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    localparam int AW = $clog2(DEPTH);

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_W-1:0]       len_q;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [PHIT_SIZE:0]     mem [DEPTH];
    logic [PHIT_SIZE:0]     head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   is_last;
    logic                   start_msg;
    logic                   start_zero;
    logic                   msg_end;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = out_valid ? head[PHIT_SIZE-1:0] : '0;
    assign out_last  = out_valid & head[PHIT_SIZE];
    assign pop       = out_valid & out_ready;
    assign is_last   = (phit_cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && (msg_len != '0)) state_nxt = S_COLLECT;
            S_COLLECT: if (push && is_last)          state_nxt = S_DRAIN;
            S_DRAIN:   if (pop && out_last)          state_nxt = S_IDLE;
            default:                                 state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        push       = (state == S_COLLECT) && in_valid && (!full || pop);
        drop       = (state == S_COLLECT) && in_valid && full && !pop;
        start_msg  = (state == S_IDLE) && start && (msg_len != '0);
        start_zero = (state == S_IDLE) && start && (msg_len == '0);
        msg_end    = (state == S_DRAIN) && pop && out_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            phit_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            done <= start_zero || msg_end;
            if (start_msg) begin
                len_q    <= msg_len;
                phit_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) phit_cnt <= phit_cnt + LEN_W'(1);
                if (drop) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; emptiness is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {is_last, in_data};
    end

endmodule

// File: tb/tb_stream_out_collector.sv
// Self-checking bench for stream_out_collector: behavioural model plus scoreboard queue,
// a vector table for the basic message and directed sequences for the corner cases.
module tb_stream_out_collector;

    localparam int PHIT  = 512;
    localparam int DEPTH = 16;
    localparam int LEN_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic [PHIT-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PHIT-1:0]  out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [LEN_W-1:0] phit_cnt;

    stream_out_collector #(.PHIT_SIZE(PHIT), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .overflow(overflow),
        .phit_cnt(phit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: 0 idle, 1 collect, 2 drain
    int              m_state;
    int              m_occ;
    logic [31:0]     m_cnt;
    logic [31:0]     m_len;
    logic            m_ovf;
    logic            m_done;
    logic [PHIT:0]   sb[$];
    logic            prev_stall;
    logic [PHIT-1:0] prev_data;

    typedef struct {
        logic            st;
        logic [31:0]     ml;
        logic            iv;
        logic [PHIT-1:0] d;
        logic            ordy;
        logic            e_ov;
        logic [PHIT-1:0] e_d;
        logic            e_last;
        logic            e_done;
        logic            e_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [PHIT-1:0] act, input logic [PHIT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_occ      = 0;
        m_cnt      = '0;
        m_len      = '0;
        m_ovf      = 1'b0;
        m_done     = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        sb.delete();
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic st, input logic [31:0] ml, input logic iv,
                        input logic [PHIT-1:0] d, input logic ordy);
        logic pop_m;
        logic popped_last;
        logic acc;
        logic lst;
        logic nd;
        start     = st;
        msg_len   = ml;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("out_valid", out_valid, (m_occ != 0));
        if (out_valid && m_occ != 0) begin
            chk("out_data", out_data, sb[0][PHIT-1:0]);
            chk("out_last", out_last, sb[0][PHIT]);
        end
        if (prev_stall) chk("stall_hold", out_data, prev_data);
        chk("done", done, m_done);
        chk("busy", busy, (m_state != 0));
        chk("overflow", overflow, m_ovf);
        chk("phit_cnt", phit_cnt, m_cnt);
        prev_stall = out_valid && !ordy;
        prev_data  = out_data;

        pop_m       = (m_occ != 0) && ordy;
        popped_last = 1'b0;
        if (pop_m) begin
            popped_last = sb[0][PHIT];
            void'(sb.pop_front());
        end
        acc = (m_state == 1) && iv && ((m_occ < DEPTH) || pop_m);
        nd  = 1'b0;
        case (m_state)
            0: if (st) begin
                if (ml != 0) begin
                    m_state = 1; m_len = ml; m_cnt = 0; m_ovf = 1'b0;
                end else nd = 1'b1;
            end
            1: begin
                if (acc) begin
                    lst = (m_cnt == m_len - 1);
                    sb.push_back({lst, d});
                    m_cnt = m_cnt + 1;
                    if (lst) m_state = 2;
                end else if (iv) m_ovf = 1'b1;
            end
            default: if (popped_last) begin
                m_state = 0; nd = 1'b1;
            end
        endcase
        m_occ  = m_occ + int'(acc) - int'(pop_m);
        m_done = nd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input bit rnd);
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (m_done) begin ok = 1; break; end
            step(1'b0, 0, 1'b0, '0, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: done not seen within 400 cycles");
        end
    endtask

    function automatic logic [PHIT-1:0] rnd_phit();
        logic [PHIT-1:0] r;
        for (int w = 0; w < PHIT / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 32'd4, 1'b0, 512'd0, 1'b1, 1'b0, 512'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'd0, 1'b1, 512'd3, 1'b1, 1'b0, 512'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 32'd0, 1'b1, 512'd4, 1'b1, 1'b1, 512'd3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'd0, 1'b1, 512'd5, 1'b1, 1'b1, 512'd4, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'd0, 1'b1, 512'd6, 1'b1, 1'b1, 512'd5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 32'd0, 1'b0, 512'd0, 1'b1, 1'b1, 512'd6, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 32'd0, 1'b0, 512'd0, 1'b1, 1'b0, 512'd0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'd0, 1'b0, 512'd0, 1'b1, 1'b0, 512'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; start = 1'b0; msg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();

        // reset held: inputs toggle, outputs stay quiet
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            start = i[0]; msg_len = 4; in_valid = 1'b1; in_data = PHIT'(i + 9); out_ready = 1'b1;
            #1;
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_phit_cnt", phit_cnt, '0);
            chk("rst_overflow", overflow, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        step(1'b0, 0, 1'b0, '0, 1'b0);

        // reset in the middle of a message
        step(1'b1, 8, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, PHIT'(50 + i), 1'b0);
        chk("mid_cnt_pre", phit_cnt, 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_cnt", phit_cnt, '0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b0, 0, 1'b0, '0, 1'b1);

        // basic 4-phit message from the vector table
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_d);
                chk($sformatf("tbl%0d_last", i), out_last, tbl[i].e_last);
            end
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            step(tbl[i].st, tbl[i].ml, tbl[i].iv, tbl[i].d, tbl[i].ordy);
        end

        // overflow: 20 phits into a stalled 16-deep FIFO, then 4 more while draining
        step(1'b1, 20, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b1, PHIT'(100 + i), 1'b0);
        chk("ovf_cnt", phit_cnt, 16);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, PHIT'(200 + i), 1'b1);
        chk("ovf_cnt_end", phit_cnt, 20);
        drain(1'b0);
        step(1'b0, 0, 1'b0, '0, 1'b1);

        // full FIFO with simultaneous push/pop, 40 phits across pointer wrap
        step(1'b1, 40, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 0, 1'b1, rnd_phit(), 1'b0);
        step(1'b0, 0, 1'b1, rnd_phit(), 1'b1);
        chk("full_pp_cnt", phit_cnt, 17);
        chk("full_pp_ovf", overflow, 1'b0);
        for (int i = 0; i < 23; i++) step(1'b0, 0, 1'b1, rnd_phit(), 1'b1);
        chk("wrap_ovf", overflow, 1'b0);
        drain(1'b0);
        step(1'b0, 0, 1'b0, '0, 1'b1);

        // zero-length message, start while busy, start in the done cycle
        step(1'b1, 0, 1'b0, '0, 1'b1);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        step(1'b0, 0, 1'b0, '0, 1'b1);
        step(1'b1, 3, 1'b0, '0, 1'b0);
        step(1'b0, 0, 1'b1, PHIT'(31), 1'b0);
        step(1'b1, 10, 1'b1, PHIT'(32), 1'b0);
        step(1'b0, 0, 1'b1, PHIT'(33), 1'b0);
        step(1'b0, 0, 1'b1, PHIT'(34), 1'b0);
        chk("busy_start_cnt", phit_cnt, 3);
        drain(1'b0);
        step(1'b1, 5, 1'b0, '0, 1'b1);
        chk("done_start_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, rnd_phit(), 1'b1);
        drain(1'b0);
        step(1'b0, 0, 1'b0, '0, 1'b1);

        // 64-phit message with random input gaps and egress stalls
        step(1'b1, 64, 1'b0, '0, 1'b0);
        begin
            bit ok = 0;
            for (int k = 0; k < 3000; k++) begin
                if (m_state == 2) begin ok = 1; break; end
                step(1'b0, 0, ($urandom_range(0, 1) == 1), rnd_phit(), ($urandom_range(0, 3) != 0));
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_collect_timeout: message not collected");
            end
        end
        drain(1'b1);
        step(1'b0, 0, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
